// File: rtl/conv_result_packer_if.sv
`default_nettype none
// ============================================================================
// Module   : conv_result_packer_if
// Brief    : Result-stream and frame-handshake bundle for conv_result_packer.
// Revision : 1.0 - initial release
// ============================================================================
interface conv_result_packer_if #(
    parameter int RESULT_WIDTH  = 3,
    parameter int RESULT_HEIGHT = 3,
    parameter int BITWIDTH      = 16
);
    logic                                           conv_on;
    logic                                           in_valid;
    logic [BITWIDTH-1:0]                            in_data;
    logic                                           in_ready;
    logic [31:0]                                    anchor_l;
    logic [31:0]                                    anchor_c;
    logic [RESULT_HEIGHT*RESULT_WIDTH*BITWIDTH-1:0] result;
    logic                                           result_valid;
    logic                                           result_ready;
    logic                                           frame_done;

    modport slave (
        input  conv_on, in_valid, in_data, result_ready,
        output in_ready, anchor_l, anchor_c, result, result_valid, frame_done
    );

    modport master (
        output conv_on, in_valid, in_data, result_ready,
        input  in_ready, anchor_l, anchor_c, result, result_valid, frame_done
    );
endinterface
`default_nettype wire

// File: rtl/conv_result_packer.sv
`default_nettype none
// ============================================================================
// Module   : conv_result_packer
// Brief    : Packs a serial stream of convolution results into a flattened map
//            and presents the completed map with a valid/ready handshake.
// Revision : 1.0 - initial release
// ============================================================================
module conv_result_packer #(
    parameter int RESULT_WIDTH  = 3,
    parameter int RESULT_HEIGHT = 3,
    parameter int BITWIDTH      = 16
) (
    input  logic                 clk_en,
    input  logic                 rst_n,
    conv_result_packer_if.slave  bus
);
    localparam int          c_num_elem = RESULT_HEIGHT * RESULT_WIDTH;
    localparam int          c_map_bits = c_num_elem * BITWIDTH;
    localparam logic [31:0] c_last_col = 32'(RESULT_WIDTH - 1);
    localparam logic [31:0] c_last_row = 32'(RESULT_HEIGHT - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FILL = 2'd1,
        ST_FULL = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [31:0]           anchor_l_q, anchor_l_d;
    logic [31:0]           anchor_c_q, anchor_c_d;
    logic [c_map_bits-1:0] result_q, result_d;
    logic                  frame_done_q, frame_done_d;

    logic w_accept;
    logic w_last_col;
    logic w_last_row;

    assign w_accept   = bus.in_valid && (state_q == ST_FILL);
    assign w_last_col = (anchor_c_q == c_last_col);
    assign w_last_row = (anchor_l_q == c_last_row);

    always_ff @(posedge clk_en) begin
        if (rst_n) begin
            state_q      <= ST_IDLE;
            anchor_l_q   <= '0;
            anchor_c_q   <= '0;
            result_q     <= '0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            anchor_l_q   <= anchor_l_d;
            anchor_c_q   <= anchor_c_d;
            result_q     <= result_d;
            frame_done_q <= frame_done_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        anchor_l_d   = anchor_l_q;
        anchor_c_d   = anchor_c_q;
        result_d     = result_q;
        frame_done_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (bus.conv_on) begin
                    state_d    = ST_FILL;
                    anchor_l_d = '0;
                    anchor_c_d = '0;
                end
            end

            ST_FILL: begin
                if (w_accept) begin
                    // Element (0,0) lands in the MSBs, same order as the image flattening.
                    for (int r = 0; r < RESULT_HEIGHT; r++) begin
                        for (int c = 0; c < RESULT_WIDTH; c++) begin
                            if (anchor_l_q == 32'(r) && anchor_c_q == 32'(c)) begin
                                result_d[(c_num_elem - (r*RESULT_WIDTH + c))*BITWIDTH - 1 -: BITWIDTH] = bus.in_data;
                            end
                        end
                    end
                    if (w_last_col) begin
                        anchor_c_d = '0;
                        anchor_l_d = anchor_l_q + 32'd1;
                    end else begin
                        anchor_c_d = anchor_c_q + 32'd1;
                    end
                end

                // Abort wins over frame completion; the data write above still happens.
                if (!bus.conv_on) begin
                    state_d    = ST_IDLE;
                    anchor_l_d = '0;
                    anchor_c_d = '0;
                end else if (w_accept && w_last_col && w_last_row) begin
                    state_d      = ST_FULL;
                    anchor_l_d   = '0;
                    anchor_c_d   = '0;
                    frame_done_d = 1'b1;
                end
            end

            ST_FULL: begin
                if (bus.result_ready) begin
                    state_d = bus.conv_on ? ST_FILL : ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign bus.in_ready     = (state_q == ST_FILL);
    assign bus.result_valid = (state_q == ST_FULL);
    assign bus.anchor_l     = anchor_l_q;
    assign bus.anchor_c     = anchor_c_q;
    assign bus.result       = result_q;
    assign bus.frame_done   = frame_done_q;

endmodule
`default_nettype wire

// File: tb/tb_conv_result_packer.sv
`default_nettype none
// ============================================================================
// Module   : tb_conv_result_packer
// Brief    : Directed, table-driven self-checking bench for conv_result_packer.
// Revision : 1.0 - initial release
// ============================================================================
module tb_conv_result_packer;
    localparam int W  = 3;
    localparam int H  = 3;
    localparam int BW = 16;
    localparam int RW = W * H * BW;

    localparam logic [RW-1:0] c_fwd  = 144'h0001_0002_0003_0004_0005_0006_0007_0008_0009;
    localparam logic [RW-1:0] c_rev  = 144'h0009_0008_0007_0006_0005_0004_0003_0002_0001;
    localparam logic [RW-1:0] c_half = {9{16'h3C00}};
    localparam logic [RW-1:0] c_part = 144'hAAAA_AAAA_AAAA_AAAA_BBBB_0006_0007_0008_0009;

    typedef struct {
        logic        v;
        logic [15:0] d;
        int          l;
        int          c;
        logic        rdy;
        logic        done;
        logic        rv;
    } vec_t;

    logic clk_en = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;
    vec_t tbl[17];

    always #5 clk_en = ~clk_en;

    conv_result_packer_if #(.RESULT_WIDTH(W), .RESULT_HEIGHT(H), .BITWIDTH(BW)) bus ();

    conv_result_packer #(.RESULT_WIDTH(W), .RESULT_HEIGHT(H), .BITWIDTH(BW)) dut (
        .clk_en (clk_en),
        .rst_n  (rst_n),
        .bus    (bus)
    );

    task automatic chk(input string name, input logic [RW-1:0] act, input logic [RW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_anchor(input string name, input int l, input int c);
        chk({name, ".l"}, RW'(bus.anchor_l), RW'(l));
        chk({name, ".c"}, RW'(bus.anchor_c), RW'(c));
    endtask

    task automatic step();
        @(posedge clk_en);
        @(negedge clk_en);
    endtask

    task automatic feed(input logic [15:0] d);
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        step();
    endtask

    task automatic handshake();
        bus.in_valid     = 1'b0;
        bus.result_ready = 1'b1;
        step();
        bus.result_ready = 1'b0;
    endtask

    initial begin
        // Bubble pattern: accepts on even entries, idle entries carry junk data.
        tbl[0]  = '{1'b1, 16'h0001, 0, 1, 1'b1, 1'b0, 1'b0};
        tbl[1]  = '{1'b0, 16'hDEAD, 0, 1, 1'b1, 1'b0, 1'b0};
        tbl[2]  = '{1'b1, 16'h0002, 0, 2, 1'b1, 1'b0, 1'b0};
        tbl[3]  = '{1'b0, 16'hDEAD, 0, 2, 1'b1, 1'b0, 1'b0};
        tbl[4]  = '{1'b1, 16'h0003, 1, 0, 1'b1, 1'b0, 1'b0};
        tbl[5]  = '{1'b0, 16'hDEAD, 1, 0, 1'b1, 1'b0, 1'b0};
        tbl[6]  = '{1'b1, 16'h0004, 1, 1, 1'b1, 1'b0, 1'b0};
        tbl[7]  = '{1'b0, 16'hDEAD, 1, 1, 1'b1, 1'b0, 1'b0};
        tbl[8]  = '{1'b1, 16'h0005, 1, 2, 1'b1, 1'b0, 1'b0};
        tbl[9]  = '{1'b0, 16'hDEAD, 1, 2, 1'b1, 1'b0, 1'b0};
        tbl[10] = '{1'b1, 16'h0006, 2, 0, 1'b1, 1'b0, 1'b0};
        tbl[11] = '{1'b0, 16'hDEAD, 2, 0, 1'b1, 1'b0, 1'b0};
        tbl[12] = '{1'b1, 16'h0007, 2, 1, 1'b1, 1'b0, 1'b0};
        tbl[13] = '{1'b0, 16'hDEAD, 2, 1, 1'b1, 1'b0, 1'b0};
        tbl[14] = '{1'b1, 16'h0008, 2, 2, 1'b1, 1'b0, 1'b0};
        tbl[15] = '{1'b0, 16'hDEAD, 2, 2, 1'b1, 1'b0, 1'b0};
        tbl[16] = '{1'b1, 16'h0009, 0, 0, 1'b0, 1'b1, 1'b1};

        bus.conv_on      = 1'b0;
        bus.in_valid     = 1'b0;
        bus.in_data      = '0;
        bus.result_ready = 1'b0;
        rst_n            = 1'b1;
        step();
        step();

        // Reset state
        chk("rst.in_ready", RW'(bus.in_ready), '0);
        chk("rst.result_valid", RW'(bus.result_valid), '0);
        chk("rst.frame_done", RW'(bus.frame_done), '0);
        chk("rst.result", bus.result, '0);
        chk_anchor("rst.anchor", 0, 0);

        // Basic 3x3 frame
        rst_n       = 1'b0;
        bus.conv_on = 1'b1;
        step();
        chk("basic.in_ready", RW'(bus.in_ready), RW'(1));
        for (int i = 1; i <= 9; i++) begin
            feed(16'(i));
            if (i == 8) chk("basic.done_early", RW'(bus.frame_done), '0);
        end
        chk("basic.frame_done", RW'(bus.frame_done), RW'(1));
        chk("basic.result_valid", RW'(bus.result_valid), RW'(1));
        chk("basic.in_ready", RW'(bus.in_ready), '0);
        chk("basic.result", bus.result, c_fwd);
        chk_anchor("basic.anchor", 0, 0);

        // Backpressure: held frame ignores input
        bus.in_valid = 1'b1;
        bus.in_data  = 16'hFFFF;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("bp.result_valid", RW'(bus.result_valid), RW'(1));
            chk("bp.in_ready", RW'(bus.in_ready), '0);
            chk("bp.result", bus.result, c_fwd);
            if (i == 0) chk("bp.done_pulse", RW'(bus.frame_done), '0);
        end
        bus.result_ready = 1'b1;
        step();
        bus.result_ready = 1'b0;
        bus.in_valid     = 1'b0;
        chk("bp.result_valid_drop", RW'(bus.result_valid), '0);
        chk("bp.in_ready_resume", RW'(bus.in_ready), RW'(1));
        chk_anchor("bp.anchor", 0, 0);

        // Bubbles, table-driven
        for (int i = 0; i < 17; i++) begin
            bus.in_valid = tbl[i].v;
            bus.in_data  = tbl[i].d;
            step();
            chk_anchor($sformatf("bub[%0d].anchor", i), tbl[i].l, tbl[i].c);
            chk($sformatf("bub[%0d].in_ready", i), RW'(bus.in_ready), RW'(tbl[i].rdy));
            chk($sformatf("bub[%0d].frame_done", i), RW'(bus.frame_done), RW'(tbl[i].done));
            chk($sformatf("bub[%0d].result_valid", i), RW'(bus.result_valid), RW'(tbl[i].rv));
        end
        bus.in_valid = 1'b0;
        chk("bub.result", bus.result, c_fwd);
        handshake();
        chk("bub.result_valid_drop", RW'(bus.result_valid), '0);

        // Abort: four accepts, then a fifth accept coinciding with conv_on drop
        for (int i = 0; i < 4; i++) feed(16'hAAAA);
        chk_anchor("abort.pre", 1, 1);
        bus.conv_on = 1'b0;
        feed(16'hBBBB);
        bus.in_valid = 1'b0;
        chk("abort.in_ready", RW'(bus.in_ready), '0);
        chk("abort.frame_done", RW'(bus.frame_done), '0);
        chk("abort.result_valid", RW'(bus.result_valid), '0);
        chk("abort.result", bus.result, c_part);
        chk_anchor("abort.anchor", 0, 0);
        step();
        chk("abort.idle_hold", RW'(bus.in_ready), '0);
        chk("abort.rv_hold", RW'(bus.result_valid), '0);
        bus.conv_on = 1'b1;
        step();
        chk("abort.restart", RW'(bus.in_ready), RW'(1));
        for (int i = 0; i < 9; i++) feed(16'h3C00);
        chk("abort.frame_done", RW'(bus.frame_done), RW'(1));
        chk("abort.refill", bus.result, c_half);
        handshake();

        // Reset mid-fill
        for (int i = 0; i < 5; i++) feed(16'h1234);
        bus.in_valid = 1'b0;
        rst_n        = 1'b1;
        step();
        rst_n        = 1'b0;
        chk("midrst.result", bus.result, '0);
        chk("midrst.in_ready", RW'(bus.in_ready), '0);
        chk_anchor("midrst.anchor", 0, 0);

        // Back-to-back frames with result_ready tied high
        bus.result_ready = 1'b1;
        step();
        for (int i = 1; i <= 9; i++) feed(16'(i));
        chk("b2b.rv1", RW'(bus.result_valid), RW'(1));
        chk("b2b.result1", bus.result, c_fwd);
        step();
        chk("b2b.rv1_drop", RW'(bus.result_valid), '0);
        chk("b2b.in_ready", RW'(bus.in_ready), RW'(1));
        for (int i = 9; i >= 1; i--) feed(16'(i));
        chk("b2b.rv2", RW'(bus.result_valid), RW'(1));
        chk("b2b.result2", bus.result, c_rev);
        bus.in_valid = 1'b0;
        step();
        chk("b2b.rv2_drop", RW'(bus.result_valid), '0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
